edu_tpu_ctrl: RTL and testbench
===============================

Name: edu_tpu_ctrl

Overview:
Parametrised, single-clock Wishbone slave that fronts an N×N systolic array (sysa-class, external) for the Caravel user area. It replaces the split-clock loader with:
- a memory-mapped weight bank;
- a synchronous input FIFO;
- a run/drain sequencer with per-column skewed result capture;
- a readable result buffer, status register and done interrupt.

Parameters:
BASE_ADDRESS, 32'h3000_0000, byte base of 32-byte register window
ARRAY_N, 3, array rows/columns; constraint ARRAY_N*DATA_W <= 32
DATA_W, 8, weight/input element width
ACC_W, 16, result element width (<= 32)
FIFO_DEPTH, 16, input FIFO entries (power of 2, >= ARRAY_N)
SA_LAT, 1, array latency from first fed vector to row 0 on column 0

Ports:
caravel_wb_clk_i  in  1  sole clock
caravel_wb_rst_n_i  in  1  reset, synchronous, active-low
caravel_wb_stb_i  in  1  strobe
caravel_wb_cyc_i  in  1  cycle
caravel_wb_we_i  in  1  write enable
caravel_wb_sel_i  in  4  byte select (ignored; full-word access only)
caravel_wb_dat_i  in  32  write data
caravel_wb_adr_i  in  32  byte address
caravel_wb_ack_o  out  1  ack
caravel_wb_dat_o  out  32  read data
sa_en_o  out  1  array enable
sa_w_o  out  ARRAY_N*ARRAY_N*DATA_W  weight bank, element k at [k*DATA_W+:DATA_W]
sa_in_o  out  ARRAY_N*DATA_W  input vector to array
sa_out_i  in  ARRAY_N*ACC_W  column outputs, column j at [j*ACC_W+:ACC_W]
irq_o  out  1  level interrupt: done & irq_en

Behaviour:
Reset and bus response:
- Reset (caravel_wb_rst_n_i low at a clock edge): all outputs 0; weights, pointers, FIFO, result buffer, done, overflow and irq_en cleared; FSM = IDLE.
- Hit: stb & cyc & adr in [BASE, BASE+0x1F] & !ack_o. A hit acks on the next edge; ack lasts 1 cycle, so there is never a back-to-back double ack.
- Read data is registered with the ack. Addresses outside the window never ack.
Register map (offset):
- 0x00 CTRL W: bit0 start, bit1 clear, bit2 irq_en (held). Reads return irq_en in bit2.
- 0x04 STATUS R:
  - bit0 busy; bit1 done; bit2 fifo_full; bit3 fifo_empty; bit4 overflow (sticky);
  - [15:8] fifo level; [23:16] weight ptr; [31:24] result ptr.
- 0x08 WEIGHT W: writes dat_i[DATA_W-1:0] to element wptr. wptr increments and wraps at ARRAY_N². Ignored while busy.
- 0x0C INPUT W: pushes dat_i[ARRAY_N*DATA_W-1:0] into the FIFO. If the FIFO is full, the data is dropped, overflow is set, and the access is still acked.
- 0x10 RESULT R: if done, returns the element at rptr sign-extended to 32 bits; rptr then increments and wraps at ARRAY_N². If not done, returns 0 and rptr is unchanged.
- 0x14–0x1C: read 0, writes ignored, acked.
FSM IDLE/RUN/DONE:
- IDLE→RUN on start when fifo level >= ARRAY_N. Otherwise start is ignored. On this transition: counter k=0, done=0, rptr=0.
- RUN, each cycle: sa_en_o=1 and k increments.
  - k<ARRAY_N: pop the FIFO head onto sa_in_o (registered, same cycle as sa_en_o).
  - Otherwise: sa_in_o=0.
  - Capture: for each column j, if r=k-j-SA_LAT is in [0,ARRAY_N-1], result[r*ARRAY_N+j] <= sa_out_i[j].
  - Leave RUN after k = 2*ARRAY_N-2+SA_LAT; set done; go to DONE with sa_en_o=0.
- DONE: idles and serves reads. A new start (FIFO refilled) re-enters RUN, and the result buffer is overwritten. Otherwise DONE holds until clear.
- busy = (state == RUN). Start while busy is ignored.
- clear: flushes the FIFO and zeroes wptr, rptr, done, overflow and the result buffer; weights are kept; FSM→IDLE, even mid-RUN, aborting it with sa_en_o=0 next cycle.
- Start and clear in the same write: clear wins.
- INPUT pushes during RUN are accepted. A push and a pop in the same cycle leave the level unchanged.

Decomposition:
- Package edu_tpu_pkg: register offsets, CTRL/STATUS bit indices, FSM state encodings.
- One sub-module: sync_fifo (parametrised width/depth, push/pop/full/empty/level; push-when-full dropped with an overflow pulse).

Test Plan:
Bench model: behavioural array, out = x·W, SA_LAT=1; N=3, DATA_W=8, ACC_W=16.
1. Write identity weights (9 writes); push [1,2,3],[4,5,6],[7,8,9]; start → busy for 2N-1+SA_LAT=6 cycles, done=1; nine RESULT reads return 1..9.
2. Weights all 2; same inputs; irq_en=1 → irq_o rises with done; results row r = 2·sum(row r) = 12,12,12,30,30,30,48,48,48.
3. Push 17 words into the 16-deep FIFO → STATUS level=16, full=1, overflow=1; the 17th word is never fed to sa_in_o.
4. Start with level=2 → no RUN, busy stays 0. RESULT read before done → 0, rptr stays 0.
5. clear issued at RUN cycle k=2 → sa_en_o=0 next cycle; STATUS=fifo_empty only; weights readable as unchanged by a rerun after refill.
6. Reset low for 1 cycle mid-RUN → all outputs 0 next cycle. A bus access one cycle after reset releases acks exactly once.

Source files
------------

// File: rtl/edu_tpu_pkg.sv
// rtl/edu_tpu_pkg.sv - register offsets, CTRL/STATUS bit indices and sequencer states
package edu_tpu_pkg;

    localparam logic [4:0] OFF_CTRL   = 5'h00;
    localparam logic [4:0] OFF_STATUS = 5'h04;
    localparam logic [4:0] OFF_WEIGHT = 5'h08;
    localparam logic [4:0] OFF_INPUT  = 5'h0C;
    localparam logic [4:0] OFF_RESULT = 5'h10;

    localparam int CTRL_START  = 0;
    localparam int CTRL_CLEAR  = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_DONE  = 1;
    localparam int STAT_FULL  = 2;
    localparam int STAT_EMPTY = 3;
    localparam int STAT_OVF   = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO; push-when-full is dropped with a one-cycle overflow pulse
module sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      level_q;
    logic             do_push, do_pop;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign data_o  = mem_q[rd_q];

    // A pop in the same cycle frees a slot, so a push to a full FIFO is still taken then.
    assign do_pop     = pop_i & ~empty_o;
    assign do_push    = push_i & (~full_o | do_pop);
    assign overflow_o = push_i & ~do_push;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || flush_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && rst_n_i && !flush_i) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/edu_tpu_ctrl.sv
// rtl/edu_tpu_ctrl.sv - Wishbone front end and run/drain sequencer for an NxN systolic array
module edu_tpu_ctrl
    import edu_tpu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
    parameter int          ARRAY_N      = 3,
    parameter int          DATA_W       = 8,
    parameter int          ACC_W        = 16,
    parameter int          FIFO_DEPTH   = 16,
    parameter int          SA_LAT       = 1
) (
    input  logic                                caravel_wb_clk_i,
    input  logic                                caravel_wb_rst_n_i,
    input  logic                                caravel_wb_stb_i,
    input  logic                                caravel_wb_cyc_i,
    input  logic                                caravel_wb_we_i,
    input  logic [3:0]                          caravel_wb_sel_i,
    input  logic [31:0]                         caravel_wb_dat_i,
    input  logic [31:0]                         caravel_wb_adr_i,
    output logic                                caravel_wb_ack_o,
    output logic [31:0]                         caravel_wb_dat_o,
    output logic                                sa_en_o,
    output logic [ARRAY_N*ARRAY_N*DATA_W-1:0]   sa_w_o,
    output logic [ARRAY_N*DATA_W-1:0]           sa_in_o,
    input  logic [ARRAY_N*ACC_W-1:0]            sa_out_i,
    output logic                                irq_o
);

    localparam int              NN      = ARRAY_N * ARRAY_N;
    localparam int              VW      = ARRAY_N * DATA_W;
    localparam int              PW      = $clog2(NN);
    localparam int              LW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [7:0]      LAST_K  = 8'(2*ARRAY_N - 2 + SA_LAT);
    localparam logic [7:0]      N_K     = 8'(ARRAY_N);
    localparam logic [LW-1:0]   N_LVL   = LW'(ARRAY_N);
    localparam logic [PW-1:0]   PTR_MAX = PW'(NN - 1);

    state_e          state_q;
    logic [7:0]      k_q;
    logic [PW-1:0]   wptr_q, rptr_q;
    logic            ack_q, done_q, ovf_q, irq_en_q, sa_en_q;
    logic [31:0]     dat_q;
    logic [VW-1:0]   sa_in_q;
    logic [DATA_W-1:0] w_q   [NN];
    logic [ACC_W-1:0]  res_q [NN];

    logic [31:0]     offset_w, rdata_d;
    logic [4:0]      off;
    logic            in_win, hit, wr, rd, ctrl_wr, clear, start, start_ok;
    logic            push, pop, weight_wr, result_rd;
    logic [VW-1:0]   fifo_head;
    logic            fifo_full, fifo_empty, fifo_ovf;
    logic [LW-1:0]   fifo_level;
    logic [NN-1:0]   cap_en;
    logic            unused_ok;

    assign offset_w  = caravel_wb_adr_i - BASE_ADDRESS;
    assign off       = offset_w[4:0];
    assign in_win    = (caravel_wb_adr_i >= BASE_ADDRESS) && (caravel_wb_adr_i <= BASE_ADDRESS + 32'h1F);
    assign hit       = caravel_wb_stb_i & caravel_wb_cyc_i & in_win & ~ack_q;
    assign wr        = hit & caravel_wb_we_i;
    assign rd        = hit & ~caravel_wb_we_i;
    assign ctrl_wr   = wr && (off == OFF_CTRL);
    assign clear     = ctrl_wr && caravel_wb_dat_i[CTRL_CLEAR];
    assign start     = ctrl_wr && caravel_wb_dat_i[CTRL_START] && !caravel_wb_dat_i[CTRL_CLEAR];
    assign start_ok  = start && (state_q != S_RUN) && (fifo_level >= N_LVL);
    assign push      = wr && (off == OFF_INPUT);
    assign weight_wr = wr && (off == OFF_WEIGHT) && (state_q != S_RUN);
    assign result_rd = rd && (off == OFF_RESULT) && done_q;
    // Vector 0 is popped on the entry edge so it is on sa_in_o during RUN cycle k=0.
    assign pop       = ~clear & (start_ok | ((state_q == S_RUN) && (k_q != LAST_K) && ((k_q + 8'd1) < N_K)));
    assign unused_ok = ^{caravel_wb_sel_i, caravel_wb_dat_i, offset_w};

    sync_fifo #(
        .WIDTH (VW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (caravel_wb_clk_i),
        .rst_n_i    (caravel_wb_rst_n_i),
        .flush_i    (clear),
        .push_i     (push),
        .data_i     (caravel_wb_dat_i[VW-1:0]),
        .pop_i      (pop),
        .data_o     (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .level_o    (fifo_level),
        .overflow_o (fifo_ovf)
    );

    always_comb begin
        rdata_d = '0;
        case (off)
            OFF_CTRL:   rdata_d[CTRL_IRQ_EN] = irq_en_q;
            OFF_STATUS: begin
                rdata_d[STAT_BUSY]  = (state_q == S_RUN);
                rdata_d[STAT_DONE]  = done_q;
                rdata_d[STAT_FULL]  = fifo_full;
                rdata_d[STAT_EMPTY] = fifo_empty;
                rdata_d[STAT_OVF]   = ovf_q;
                rdata_d[15:8]       = 8'(fifo_level);
                rdata_d[23:16]      = 8'(wptr_q);
                rdata_d[31:24]      = 8'(rptr_q);
            end
            OFF_RESULT: if (done_q) rdata_d = 32'($signed(res_q[rptr_q]));
            default:    ;
        endcase
    end

    // Column j sees row r of the result SA_LAT+j cycles after that row's vector was fed.
    always_comb begin
        cap_en = '0;
        for (int r = 0; r < ARRAY_N; r++) begin
            for (int j = 0; j < ARRAY_N; j++) begin
                cap_en[r*ARRAY_N + j] = (state_q == S_RUN) && (k_q == 8'(r + j + SA_LAT));
            end
        end
    end

    always_comb begin
        sa_w_o = '0;
        for (int e = 0; e < NN; e++) sa_w_o[e*DATA_W +: DATA_W] = w_q[e];
    end

    always_ff @(posedge caravel_wb_clk_i) begin
        if (!caravel_wb_rst_n_i) begin
            for (int e = 0; e < NN; e++) w_q[e] <= '0;
        end else if (weight_wr) begin
            w_q[wptr_q] <= caravel_wb_dat_i[DATA_W-1:0];
        end
    end

    always_ff @(posedge caravel_wb_clk_i) begin
        if (!caravel_wb_rst_n_i || clear) begin
            for (int e = 0; e < NN; e++) res_q[e] <= '0;
        end else begin
            for (int e = 0; e < NN; e++) begin
                if (cap_en[e]) res_q[e] <= sa_out_i[(e % ARRAY_N)*ACC_W +: ACC_W];
            end
        end
    end

    always_ff @(posedge caravel_wb_clk_i) begin
        if (!caravel_wb_rst_n_i) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            ack_q    <= 1'b0;
            dat_q    <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            irq_en_q <= 1'b0;
            sa_en_q  <= 1'b0;
            sa_in_q  <= '0;
        end else begin
            ack_q <= hit;
            dat_q <= rd ? rdata_d : 32'h0;
            if (ctrl_wr)   irq_en_q <= caravel_wb_dat_i[CTRL_IRQ_EN];
            if (fifo_ovf)  ovf_q    <= 1'b1;
            if (weight_wr) wptr_q   <= (wptr_q == PTR_MAX) ? '0 : wptr_q + PW'(1);
            if (result_rd) rptr_q   <= (rptr_q == PTR_MAX) ? '0 : rptr_q + PW'(1);

            if (clear) begin
                state_q <= S_IDLE;
                k_q     <= '0;
                done_q  <= 1'b0;
                ovf_q   <= 1'b0;
                wptr_q  <= '0;
                rptr_q  <= '0;
                sa_en_q <= 1'b0;
                sa_in_q <= '0;
            end else begin
                case (state_q)
                    S_IDLE, S_DONE: begin
                        if (start_ok) begin
                            state_q <= S_RUN;
                            k_q     <= '0;
                            done_q  <= 1'b0;
                            rptr_q  <= '0;
                            sa_en_q <= 1'b1;
                            sa_in_q <= fifo_head;
                        end
                    end
                    S_RUN: begin
                        if (k_q == LAST_K) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            sa_en_q <= 1'b0;
                            sa_in_q <= '0;
                        end else begin
                            k_q     <= k_q + 8'd1;
                            sa_en_q <= 1'b1;
                            sa_in_q <= ((k_q + 8'd1) < N_K) ? fifo_head : '0;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign caravel_wb_ack_o = ack_q;
    assign caravel_wb_dat_o = dat_q;
    assign sa_en_o          = sa_en_q;
    assign sa_in_o          = sa_in_q;
    assign irq_o            = done_q & irq_en_q;

endmodule

// File: tb/tb_edu_tpu_ctrl.sv
// tb/tb_edu_tpu_ctrl.sv - self-checking bench with a behavioural 3x3 array (out = x.W, latency 1)
module tb_edu_tpu_ctrl;

    localparam int          N    = 3;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] dat_i, adr, dat_o;
    logic        ack, sa_en, irq;
    logic [71:0] sa_w;
    logic [23:0] sa_in;
    logic [47:0] sa_out;

    always #5 clk = ~clk;

    edu_tpu_ctrl #(
        .BASE_ADDRESS (BASE),
        .ARRAY_N      (3),
        .DATA_W       (8),
        .ACC_W        (16),
        .FIFO_DEPTH   (16),
        .SA_LAT       (1)
    ) dut (
        .caravel_wb_clk_i   (clk),
        .caravel_wb_rst_n_i (rst_n),
        .caravel_wb_stb_i   (stb),
        .caravel_wb_cyc_i   (cyc),
        .caravel_wb_we_i    (we),
        .caravel_wb_sel_i   (sel),
        .caravel_wb_dat_i   (dat_i),
        .caravel_wb_adr_i   (adr),
        .caravel_wb_ack_o   (ack),
        .caravel_wb_dat_o   (dat_o),
        .sa_en_o            (sa_en),
        .sa_w_o             (sa_w),
        .sa_in_o            (sa_in),
        .sa_out_i           (sa_out),
        .irq_o              (irq)
    );

    typedef struct packed {
        logic [8:0][7:0]  w;
        logic [8:0][7:0]  x;
        logic [8:0][15:0] r;
        logic             irq;
    } vec_t;

    vec_t        tbl [3];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q  [$];
    logic [23:0] feed_q [$];
    logic [23:0] fed    [8];
    int          en_cnt = 0;
    int          ack_cnt = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Behavioural array: column j presents row r = en_cnt - j - 1 built from previously fed vectors.
    always @(posedge clk) begin
        if (!sa_en) en_cnt <= 0;
        else begin
            if (en_cnt < 8) fed[en_cnt] <= sa_in;
            en_cnt <= en_cnt + 1;
        end
    end

    always @(negedge clk) begin
        int r, acc;
        for (int j = 0; j < N; j++) begin
            r = en_cnt - j - 1;
            if (sa_en && r >= 0 && r < N) begin
                acc = 0;
                for (int i = 0; i < N; i++)
                    acc += int'($signed(fed[r][i*8 +: 8])) * int'($signed(sa_w[(i*N + j)*8 +: 8]));
                sa_out[j*16 +: 16] = acc[15:0];
            end else begin
                sa_out[j*16 +: 16] = 16'h5A5A;
            end
        end
    end

    always @(negedge clk) begin
        if (ack) ack_cnt++;
        if (rst_n && sa_en) begin
            if (en_cnt < N) begin
                if (feed_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL feed_unexpected: got %h expected no vector", sa_in);
                end else begin
                    chk($sformatf("feed_k%0d", en_cnt), 32'(sa_in), 32'(feed_q.pop_front()));
                end
            end else begin
                chk("feed_zero", 32'(sa_in), 32'h0);
            end
        end
    end

    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rdat, output bit ok);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; ok = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (ack) begin
                ok = 1'b1;
                break;
            end
        end
        rdat = dat_o;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [4:0] o, input logic [31:0] d);
        logic [31:0] rdat;
        bit ok;
        bus(1'b1, BASE + 32'(o), d, rdat, ok);
        chk($sformatf("wr_ack_%02h", o), 32'(ok), 32'h1);
    endtask

    task automatic rd_chk(input logic [4:0] o, input logic [31:0] e, input string name);
        logic [31:0] rdat, expv;
        bit ok;
        exp_q.push_back(e);
        bus(1'b0, BASE + 32'(o), 32'h0, rdat, ok);
        expv = exp_q.pop_front();
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got no ack expected ack", name);
        end else begin
            chk(name, rdat, expv);
        end
    endtask

    task automatic push_vec(input logic [23:0] v, input bit expect_feed);
        if (expect_feed) feed_q.push_back(v);
        wr(5'h0C, {8'h0, v});
    endtask

    task automatic wait_idle(output int cyc_n);
        cyc_n = 0;
        while (sa_en && cyc_n < 20) begin
            cyc_n++;
            @(negedge clk);
        end
        if (cyc_n >= 20) begin
            n_tests++;
            n_fail++;
            $display("FAIL run_timeout: got busy after 20 cycles expected done");
        end
    endtask

    function automatic logic [31:0] sx(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int          busy_n;
        bit          irq_seen;
        logic [31:0] rdv;
        bit          ok;
        int          a0;

        for (int i = 0; i < 9; i++) begin
            tbl[0].w[i] = (i % 4 == 0) ? 8'd1 : 8'd0;
            tbl[0].x[i] = 8'(i + 1);
            tbl[0].r[i] = 16'(i + 1);
            tbl[1].w[i] = 8'd2;
            tbl[1].x[i] = 8'(i + 1);
            tbl[1].r[i] = (i < 3) ? 16'd12 : (i < 6) ? 16'd30 : 16'd48;
            tbl[2].w[i] = (i % 4 == 0) ? 8'hFF : 8'd0;
            tbl[2].x[i] = 8'(i + 1);
            tbl[2].r[i] = 16'(-(i + 1));
        end
        tbl[0].irq = 1'b0;
        tbl[1].irq = 1'b1;
        tbl[2].irq = 1'b0;

        rst_n = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'hF; adr = 32'h0; dat_i = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_sa_en", 32'(sa_en), 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_sa_w", 32'(|sa_w), 32'h0);
        rst_n = 1'b1;
        rd_chk(5'h04, 32'h0000_0008, "rst_status");
        rd_chk(5'h1C, 32'h0, "reserved_read");
        bus(1'b0, BASE + 32'h20, 32'h0, rdv, ok);
        chk("out_of_window_noack", 32'(ok), 32'h0);

        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 9; i++) wr(5'h08, {24'h0, tbl[t].w[i]});
            for (int r = 0; r < N; r++) push_vec({tbl[t].x[r*3+2], tbl[t].x[r*3+1], tbl[t].x[r*3]}, 1'b1);
            wr(5'h00, {29'h0, tbl[t].irq, 2'b01});
            busy_n = 0;
            irq_seen = 1'b0;
            while (sa_en && busy_n < 20) begin
                busy_n++;
                irq_seen |= irq;
                @(negedge clk);
            end
            chk($sformatf("busy_cycles_t%0d", t), 32'(busy_n), 32'd6);
            chk($sformatf("irq_before_done_t%0d", t), 32'(irq_seen), 32'h0);
            chk($sformatf("irq_after_done_t%0d", t), 32'(irq), 32'(tbl[t].irq));
            rd_chk(5'h00, 32'(tbl[t].irq) << 2, $sformatf("ctrl_read_t%0d", t));
            rd_chk(5'h04, 32'h0000_000A, $sformatf("status_done_t%0d", t));
            for (int e = 0; e < 9; e++)
                rd_chk(5'h10, sx(tbl[t].r[e]), $sformatf("result_t%0d_e%0d", t, e));
        end

        for (int i = 0; i < 17; i++) push_vec({3{8'(i + 1)}}, i < 16);
        rd_chk(5'h04, 32'h0000_1016, "status_overflow");
        for (int n = 0; n < 5; n++) begin
            wr(5'h00, 32'h1);
            wait_idle(busy_n);
        end
        rd_chk(5'h04, 32'h0000_0112, "status_level_one");
        push_vec(24'hAABBCC, 1'b1);
        push_vec(24'h112233, 1'b1);
        wr(5'h00, 32'h1);
        wait_idle(busy_n);
        chk("feed_queue_drained", 32'(feed_q.size()), 32'h0);
        wr(5'h00, 32'h2);
        feed_q.delete();
        rd_chk(5'h04, 32'h0000_0008, "status_after_clear");

        push_vec(24'h010203, 1'b0);
        push_vec(24'h040506, 1'b0);
        wr(5'h00, 32'h1);
        @(negedge clk);
        chk("short_start_no_run", 32'(sa_en), 32'h0);
        rd_chk(5'h04, 32'h0000_0200, "status_level_two");
        rd_chk(5'h10, 32'h0, "result_not_done");
        rd_chk(5'h04, 32'h0000_0200, "rptr_unchanged");
        wr(5'h00, 32'h2);

        for (int r = 0; r < N; r++) push_vec({tbl[0].x[r*3+2], tbl[0].x[r*3+1], tbl[0].x[r*3]}, 1'b1);
        wr(5'h00, 32'h1);
        @(negedge clk);
        @(negedge clk);
        chk("clear_at_k2_en", 32'(sa_en), 32'h1);
        chk("clear_at_k2_k", 32'(en_cnt), 32'd2);
        wr(5'h00, 32'h2);
        chk("clear_midrun_en_off", 32'(sa_en), 32'h0);
        feed_q.delete();
        rd_chk(5'h04, 32'h0000_0008, "status_clear_midrun");
        for (int r = 0; r < N; r++) push_vec({tbl[0].x[r*3+2], tbl[0].x[r*3+1], tbl[0].x[r*3]}, 1'b1);
        wr(5'h00, 32'h1);
        wait_idle(busy_n);
        for (int e = 0; e < 9; e++)
            rd_chk(5'h10, sx(tbl[2].r[e]), $sformatf("weights_kept_e%0d", e));

        for (int r = 0; r < N; r++) push_vec({tbl[0].x[r*3+2], tbl[0].x[r*3+1], tbl[0].x[r*3]}, 1'b1);
        wr(5'h00, 32'h1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midrun_rst_sa_en", 32'(sa_en), 32'h0);
        chk("midrun_rst_sa_in", 32'(sa_in), 32'h0);
        chk("midrun_rst_sa_w", 32'(|sa_w), 32'h0);
        chk("midrun_rst_ack", 32'(ack), 32'h0);
        chk("midrun_rst_dat", dat_o, 32'h0);
        chk("midrun_rst_irq", 32'(irq), 32'h0);
        rst_n = 1'b1;
        feed_q.delete();
        @(negedge clk);
        a0 = ack_cnt;
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'h4;
        @(negedge clk);
        rdv = dat_o;
        @(negedge clk);
        stb = 1'b0; cyc = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_reset_ack_once", 32'(ack_cnt - a0), 32'd1);
        chk("post_reset_status", rdv, 32'h0000_0008);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
